// File: rtl/out_mem_write_ctrl.sv
// Write sequencer from the max-pool output stage into the output-memory banks.
// Steps write_count through each pooled vector and issues one bank write per beat.
module out_mem_write_ctrl #(
  parameter int N_S      = 4,
  parameter int N_C      = 4,
  parameter int N_B      = 4,
  parameter int DATA_WDT = 64,
  parameter int BANKS    = 2,
  parameter int ADDR_WDT = 10,
  localparam int V  = N_S * N_C * 16,
  localparam int DB = V / DATA_WDT,
  localparam int SB = V / (DATA_WDT * BANKS),
  localparam int CW = $clog2((N_B * V) / (DATA_WDT * BANKS)) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         layer_start,
  input  logic [ADDR_WDT-1:0]          base_addr,
  input  logic                         dense_mode,
  input  logic                         vec_valid,
  output logic                         vec_ready,
  input  logic [DATA_WDT-1:0]          dense_word,
  input  logic [BANKS*DATA_WDT-1:0]    sparse_word,
  output logic [CW-1:0]                write_count,
  input  logic                         mem_wr_ready,
  output logic [BANKS-1:0]             mem_we,
  output logic [BANKS*ADDR_WDT-1:0]    mem_addr,
  output logic [BANKS*DATA_WDT-1:0]    mem_wdata,
  output logic                         vec_done,
  output logic                         layer_done
);

  localparam int BW = ($clog2(DB) > 0) ? $clog2(DB) : 1;
  localparam int VW = ($clog2(N_B) > 0) ? $clog2(N_B) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         write_count_reg;
  logic [BW-1:0]         beat_reg;
  logic [VW-1:0]         vec_cnt_reg;
  logic [ADDR_WDT-1:0]   base_reg;
  logic                  dense_reg;
  logic                  vec_done_reg;
  logic                  layer_done_reg;

  logic                  in_write;
  logic                  beat_fire;
  logic                  last_beat;
  logic [ADDR_WDT-1:0]   dense_addr;
  logic [ADDR_WDT-1:0]   sparse_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A layer_start in the same cycle as a beat cancels that beat outright.
  always_comb begin
    state_next = state_reg;
    in_write   = (state_reg == WRITE) && !layer_start;
    beat_fire  = in_write && mem_wr_ready;
    last_beat  = dense_reg ? (beat_reg == BW'(DB - 1)) : (beat_reg == BW'(SB - 1));
    vec_ready  = (state_reg == READY);
    if (layer_start) begin
      state_next = READY;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        READY: begin
          if (vec_valid) state_next = WRITE;
        end
        WRITE: begin
          if (beat_fire && last_beat)
            state_next = (vec_cnt_reg == VW'(N_B - 1)) ? IDLE : READY;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count_reg <= '0;
      beat_reg        <= '0;
      vec_cnt_reg     <= '0;
      base_reg        <= '0;
      dense_reg       <= 1'b0;
      vec_done_reg    <= 1'b0;
      layer_done_reg  <= 1'b0;
    end else begin
      vec_done_reg   <= 1'b0;
      layer_done_reg <= 1'b0;
      if (layer_start) begin
        base_reg        <= base_addr;
        dense_reg       <= dense_mode;
        write_count_reg <= '0;
        beat_reg        <= '0;
        vec_cnt_reg     <= '0;
      end else if (beat_fire) begin
        // write_count keeps running across vectors; the muxes only see its low bits.
        write_count_reg <= write_count_reg + CW'(1);
        if (last_beat) begin
          beat_reg     <= '0;
          vec_done_reg <= 1'b1;
          if (vec_cnt_reg == VW'(N_B - 1)) begin
            vec_cnt_reg    <= '0;
            layer_done_reg <= 1'b1;
          end else begin
            vec_cnt_reg <= vec_cnt_reg + VW'(1);
          end
        end else begin
          beat_reg <= beat_reg + BW'(1);
        end
      end
    end
  end

  assign dense_addr  = base_reg + ADDR_WDT'(int'(write_count_reg) / BANKS);
  assign sparse_addr = base_reg + ADDR_WDT'(write_count_reg);

  // Dense beats land on one bank (round-robin); sparse beats hit every bank at once.
  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic bank_hit;
      assign bank_hit = ((int'(write_count_reg) % BANKS) == gi);
      assign mem_we[gi] = in_write && (!dense_reg || bank_hit);
      assign mem_addr[gi*ADDR_WDT +: ADDR_WDT] =
        in_write ? (dense_reg ? dense_addr : sparse_addr) : '0;
      assign mem_wdata[gi*DATA_WDT +: DATA_WDT] =
        in_write ? (dense_reg ? dense_word : sparse_word[gi*DATA_WDT +: DATA_WDT]) : '0;
    end
  endgenerate

  assign write_count = write_count_reg;
  assign vec_done    = vec_done_reg;
  assign layer_done  = layer_done_reg;

endmodule

// File: tb/tb_out_mem_write_ctrl.sv
// Scoreboard bench for out_mem_write_ctrl: stimulus queues expected bank writes
// and done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_out_mem_write_ctrl;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int NBK = 2;
  localparam int CW  = 4;

  typedef struct packed {
    logic [NBK-1:0] we;
    logic [AW-1:0]  a0;
    logic [AW-1:0]  a1;
    logic [DW-1:0]  d0;
    logic [DW-1:0]  d1;
    logic [CW-1:0]  wc;
  } wr_t;

  typedef struct packed {
    logic vd;
    logic ld;
  } done_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              layer_start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic              dense_mode = 1'b0;
  logic              vec_valid = 1'b0;
  logic              vec_ready;
  logic [DW-1:0]     dense_word;
  logic [NBK*DW-1:0] sparse_word;
  logic [CW-1:0]     write_count;
  logic              mem_wr_ready = 1'b1;
  logic [NBK-1:0]    mem_we;
  logic [NBK*AW-1:0] mem_addr;
  logic [NBK*DW-1:0] mem_wdata;
  logic              vec_done;
  logic              layer_done;

  int    tests = 0;
  int    fails = 0;
  int    cur_vec = 0;
  wr_t   exp_q[$];
  done_t done_q[$];
  wr_t   mon_w;
  done_t mon_d;
  bit    mon_ok;

  out_mem_write_ctrl dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .base_addr(base_addr),
    .dense_mode(dense_mode), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .dense_word(dense_word), .sparse_word(sparse_word), .write_count(write_count),
    .mem_wr_ready(mem_wr_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .vec_done(vec_done), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_pat(input int v, input int idx);
    return {16'hA5A5, v[15:0], 16'h1000, idx[15:0]};
  endfunction

  // Upstream mux model: slices the current vector by the low bits of write_count.
  always_comb begin
    dense_word  = word_pat(cur_vec, int'(write_count[1:0]));
    sparse_word = {word_pat(cur_vec, 2 * int'(write_count[0]) + 1),
                   word_pat(cur_vec, 2 * int'(write_count[0]))};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mem_we != '0 && mem_wr_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got we=%b wc=%0d required no write", mem_we, write_count);
      end else begin
        mon_w  = exp_q.pop_front();
        mon_ok = (mem_we === mon_w.we) && (write_count === mon_w.wc);
        if (mon_w.we[0]) mon_ok = mon_ok && (mem_addr[AW-1:0] === mon_w.a0) && (mem_wdata[DW-1:0] === mon_w.d0);
        if (mon_w.we[1]) mon_ok = mon_ok && (mem_addr[2*AW-1:AW] === mon_w.a1) && (mem_wdata[2*DW-1:DW] === mon_w.d1);
        if (!mon_ok) begin
          fails++;
          $display("FAIL write: got we=%b wc=%0d a=%h d=%h required we=%b wc=%0d a0=%h a1=%h d0=%h d1=%h",
                   mem_we, write_count, mem_addr, mem_wdata, mon_w.we, mon_w.wc, mon_w.a0, mon_w.a1, mon_w.d0, mon_w.d1);
        end else begin
          $display("[TB] write wc=%0d we=%b addr=%h ok", write_count, mem_we, mem_addr);
        end
      end
    end
    if (vec_done || layer_done) begin
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got vec_done=%b layer_done=%b required none", vec_done, layer_done);
      end else begin
        mon_d = done_q.pop_front();
        if (vec_done !== mon_d.vd || layer_done !== mon_d.ld) begin
          fails++;
          $display("FAIL done: got vec_done=%b layer_done=%b required %b %b", vec_done, layer_done, mon_d.vd, mon_d.ld);
        end else begin
          $display("[TB] done vec_done=%b layer_done=%b ok", vec_done, layer_done);
        end
      end
    end
  end

  task automatic push_writes(input int v, input bit dense, input int base, input int kstart, input int nb);
    wr_t e;
    int  k;
    for (int i = 0; i < nb; i++) begin
      k = kstart + i;
      if (dense) begin
        e.we = (k % 2 == 0) ? 2'b01 : 2'b10;
        e.a0 = AW'(base + k / 2);
        e.a1 = e.a0;
        e.d0 = word_pat(v, k % 4);
        e.d1 = e.d0;
      end else begin
        e.we = 2'b11;
        e.a0 = AW'(base + k);
        e.a1 = e.a0;
        e.d0 = word_pat(v, 2 * (k % 2));
        e.d1 = word_pat(v, 2 * (k % 2) + 1);
      end
      e.wc = CW'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_layer(input int base, input bit dense);
    layer_start = 1'b1;
    base_addr   = AW'(base);
    dense_mode  = dense;
    tick;
    layer_start = 1'b0;
    check("ready_after_start", 64'(vec_ready), 64'(1));
  endtask

  task automatic send_vector(input int v, input bit dense, input int base, input int kstart,
                             input bit last, input int stall_at, input int stall_len, input bit hold_valid);
    int    nb, n, cyc, j, stalled, k;
    done_t d;
    nb = dense ? 4 : 2;
    push_writes(v, dense, base, kstart, nb);
    d.vd = 1'b1;
    d.ld = last;
    done_q.push_back(d);
    cur_vec   = v;
    vec_valid = 1'b1;
    n = 0;
    while (!vec_ready && n < 20) begin
      tick;
      n++;
    end
    check("handshake_ready", 64'(vec_ready), 64'(1));
    tick;
    if (!hold_valid) vec_valid = 1'b0;
    cyc = 0; j = 0; stalled = 0;
    while (!vec_done && cyc < 40) begin
      if (hold_valid) check("ready_low_in_write", 64'(vec_ready), 64'(0));
      if (j == stall_at && stalled < stall_len) begin
        mem_wr_ready = 1'b0;
        k = kstart + j;
        check("stall_wc", 64'(write_count), 64'(k));
        if (dense) begin
          check("stall_we", 64'(mem_we), 64'((k % 2 == 0) ? 1 : 2));
          check("stall_addr", 64'(mem_addr[(k % 2)*AW +: AW]), 64'(base + k / 2));
          check("stall_data", 64'(mem_wdata[(k % 2)*DW +: DW]), 64'(word_pat(v, k % 4)));
        end
        stalled++;
      end else begin
        mem_wr_ready = 1'b1;
        j++;
      end
      tick;
      cyc++;
    end
    mem_wr_ready = 1'b1;
    vec_valid    = 1'b0;
    check("vec_done_latency", 64'(cyc), 64'(nb + stall_len));
  endtask

  initial begin
    #2 rst = 1'b1;
    tick;
    tick;
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_wc", 64'(write_count), 64'(0));
    check("rst_ready", 64'(vec_ready), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_vec_done", 64'(vec_done), 64'(0));
    check("rst_layer_done", 64'(layer_done), 64'(0));
    rst = 1'b0;
    tick;

    // Dense layer, four vectors, no back-pressure.
    start_layer(32'h010, 1'b1);
    for (int v = 0; v < 4; v++) send_vector(v, 1'b1, 32'h010, 4 * v, v == 3, -1, 0, 1'b0);
    tick;
    check("idle_after_dense_layer", 64'(vec_ready), 64'(0));

    // Sparse layer, four vectors.
    start_layer(32'h020, 1'b0);
    for (int v = 0; v < 4; v++) send_vector(10 + v, 1'b0, 32'h020, 2 * v, v == 3, -1, 0, 1'b0);
    tick;
    check("idle_after_sparse_layer", 64'(vec_ready), 64'(0));

    // Dense layer with a 3-cycle stall on beat 2, then vec_valid held through WRITE.
    start_layer(32'h030, 1'b1);
    send_vector(20, 1'b1, 32'h030, 0, 1'b0, 2, 3, 1'b0);
    send_vector(21, 1'b1, 32'h030, 4, 1'b0, -1, 0, 1'b1);
    send_vector(22, 1'b1, 32'h030, 8, 1'b0, -1, 0, 1'b0);
    send_vector(23, 1'b1, 32'h030, 12, 1'b1, -1, 0, 1'b0);
    tick;

    // Abort at beat 1 of the second vector.
    start_layer(32'h040, 1'b1);
    send_vector(30, 1'b1, 32'h040, 0, 1'b0, -1, 0, 1'b0);
    push_writes(31, 1'b1, 32'h040, 4, 1);
    cur_vec   = 31;
    vec_valid = 1'b1;
    tick;
    vec_valid = 1'b0;
    tick;
    check("pre_abort_wc", 64'(write_count), 64'(5));
    layer_start = 1'b1;
    base_addr   = AW'(32'h050);
    dense_mode  = 1'b1;
    #1;
    check("abort_we", 64'(mem_we), 64'(0));
    tick;
    layer_start = 1'b0;
    check("abort_wc", 64'(write_count), 64'(0));
    check("abort_ready", 64'(vec_ready), 64'(1));
    check("abort_vec_done", 64'(vec_done), 64'(0));
    check("abort_layer_done", 64'(layer_done), 64'(0));

    // Asynchronous reset in the middle of a WRITE.
    push_writes(40, 1'b1, 32'h050, 0, 1);
    cur_vec   = 40;
    vec_valid = 1'b1;
    tick;
    vec_valid = 1'b0;
    tick;
    check("pre_rst_we", 64'(mem_we), 64'(2));
    #2 rst = 1'b1;
    #1;
    check("async_rst_we", 64'(mem_we), 64'(0));
    check("async_rst_wc", 64'(write_count), 64'(0));
    check("async_rst_ready", 64'(vec_ready), 64'(0));
    check("async_rst_addr", 64'(mem_addr), 64'(0));
    check("async_rst_wdata_lo", 64'(mem_wdata[DW-1:0]), 64'(0));
    tick;
    tick;
    rst = 1'b0;
    vec_valid = 1'b1;
    tick;
    tick;
    tick;
    check("idle_ignores_valid_ready", 64'(vec_ready), 64'(0));
    check("idle_ignores_valid_we", 64'(mem_we), 64'(0));
    vec_valid = 1'b0;
    tick;
    tick;
    check("writes_left_over", 64'(exp_q.size()), 64'(0));
    check("dones_left_over", 64'(done_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
